// File: rtl/cla_adder_pipe.sv
// rtl/cla_adder_pipe.sv - pipelined carry-look-ahead adder/subtractor with valid/ready handshake
// Optional feature macro: CLA_ADDER_PIPE_SAT_EN (adds in_sat, signed saturation in the final stage)
module cla_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    input  logic             in_sub,
`ifdef CLA_ADDER_PIPE_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / BLOCK;
    localparam int LAST   = STAGES - 1;

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Reject geometries that cannot be split into whole CLA groups
    generate
        if ((BLOCK < 1) || (BLOCK > WIDTH) || ((WIDTH % BLOCK) != 0)) begin : g_bad_cfg
            $error("cla_adder_pipe: WIDTH must be a multiple of BLOCK and 1 <= BLOCK <= WIDTH");
        end
    endgenerate

    // One BLOCK-bit look-ahead group: returns {carry_out, carry_into_top_bit, sum}
    function automatic logic [BLOCK+1:0] cla_group(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             ci
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        return {c[BLOCK], c[BLOCK-1], p ^ c[BLOCK-1:0]};
    endfunction

    // Per-stage pipeline registers. a/b carry the operands (b already
    // inverted for subtract) so later stages can pick up their slice;
    // sum accumulates the slices resolved so far.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] c_q,     c_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  b_d   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              ovf_q, ovf_d;
`ifdef CLA_ADDER_PIPE_SAT_EN
    logic [STAGES-1:0] sat_q, sat_d;
`endif

    logic              adv;

    // Scratch values for the stage currently being evaluated
    logic [WIDTH-1:0]  st_a;
    logic [WIDTH-1:0]  st_b;
    logic [WIDTH-1:0]  st_sum;
    logic              st_c;
    logic              st_v;
    logic              st_sat;
    logic [BLOCK+1:0]  grp;
    logic [WIDTH-1:0]  new_sum;
    logic              new_ovf;

    // The whole pipe moves as one: a stall at the output freezes every stage
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign out_valid = valid_q[LAST];
    assign out_sum   = sum_q[LAST];
    assign out_c     = c_q[LAST];
    assign out_ovf   = ovf_q;

    // Next-state for every stage; data only loads behind a valid token so outputs never toggle on bubbles
    always_comb begin
        valid_d = valid_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
`ifdef CLA_ADDER_PIPE_SAT_EN
        sat_d   = sat_q;
`endif
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            sum_d[k] = sum_q[k];
        end
        st_a    = '0;
        st_b    = '0;
        st_sum  = '0;
        st_c    = 1'b0;
        st_v    = 1'b0;
        st_sat  = 1'b0;
        grp     = '0;
        new_sum = '0;
        new_ovf = 1'b0;

        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                st_a   = in_a;
                st_b   = in_sub ? ~in_b : in_b;
                st_c   = in_sub | in_c;
                st_v   = in_valid;
                st_sum = '0;
`ifdef CLA_ADDER_PIPE_SAT_EN
                st_sat = in_sat;
`else
                st_sat = 1'b0;
`endif
            end else begin
                st_a   = a_q[k-1];
                st_b   = b_q[k-1];
                st_c   = c_q[k-1];
                st_v   = valid_q[k-1];
                st_sum = sum_q[k-1];
`ifdef CLA_ADDER_PIPE_SAT_EN
                st_sat = sat_q[k-1];
`else
                st_sat = 1'b0;
`endif
            end

            grp     = cla_group(st_a[k*BLOCK +: BLOCK], st_b[k*BLOCK +: BLOCK], st_c);
            new_sum = st_sum;
            new_sum[k*BLOCK +: BLOCK] = grp[BLOCK-1:0];
            // Signed overflow: carry into MSB differs from carry out of MSB
            new_ovf = grp[BLOCK] ^ grp[BLOCK+1];

            // Saturation direction follows the sign of A (both operands share it on overflow)
            if ((k == LAST) && st_sat && new_ovf) begin
                new_sum = st_a[WIDTH-1] ? SAT_NEG : SAT_POS;
            end

            if (adv) begin
                valid_d[k] = st_v;
                if (st_v) begin
                    a_d[k]   = st_a;
                    b_d[k]   = st_b;
                    sum_d[k] = new_sum;
                    c_d[k]   = grp[BLOCK+1];
`ifdef CLA_ADDER_PIPE_SAT_EN
                    sat_d[k] = st_sat;
`endif
                    if (k == LAST) begin
                        ovf_d = new_ovf;
                    end
                end
            end
        end
    end

    // Pipeline state; reset discards everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
`ifdef CLA_ADDER_PIPE_SAT_EN
            sat_q   <= '0;
`endif
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
`ifdef CLA_ADDER_PIPE_SAT_EN
            sat_q   <= sat_d;
`endif
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// tb/tb_cla_adder_pipe.sv - self-checking bench for cla_adder_pipe
module tb_cla_adder_pipe;

    localparam int W   = 16;
    localparam int BLK = 4;
    localparam int STG = W / BLK;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_c      = 1'b0;
    logic         in_sub    = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic         in_ready;
    logic         out_valid;
    logic         out_c;
    logic         out_ovf;
    logic [W-1:0] out_sum;
`ifdef CLA_ADDER_PIPE_SAT_EN
    logic         in_sat    = 1'b0;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit cur_lat = 1'b0;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         ovf;
        int           t;
        bit           lat;
    } exp_t;

    exp_t sbq[$];

    logic [W-1:0] last_sum = '0;
    logic         last_c   = 1'b0;
    logic         last_ovf = 1'b0;
    logic [W-1:0] prev_sum = '0;
    logic         prev_c   = 1'b0;
    logic         prev_ovf = 1'b0;
    bit           prev_stall = 1'b0;

    cla_adder_pipe #(.WIDTH(W), .BLOCK(BLK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_sub    (in_sub),
`ifdef CLA_ADDER_PIPE_SAT_EN
        .in_sat    (in_sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_c     (out_c),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Arithmetic reference: plain wide addition, sign rule for overflow
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic sub, input logic sat);
        exp_t e;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb    = sub ? ~b : b;
        full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : c)};
        e.sum = full[W-1:0];
        e.c   = full[W];
        e.ovf = (a[W-1] == bb[W-1]) && (e.sum[W-1] != a[W-1]);
        if (sat && e.ovf) e.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        e.t   = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    function automatic logic cur_sat();
`ifdef CLA_ADDER_PIPE_SAT_EN
        return in_sat;
`else
        return 1'b0;
`endif
    endfunction

    // Compare process: outputs sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sbq.delete();
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_sum",   32'(out_sum),   32'd0);
            check("rst_out_c",     32'(out_c),     32'd0);
            check("rst_out_ovf",   32'(out_ovf),   32'd0);
            check("rst_in_ready",  32'(in_ready),  32'd1);
            last_sum = '0; last_c = 1'b0; last_ovf = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_stable", 32'({out_c, out_ovf, out_sum}), 32'({prev_c, prev_ovf, prev_sum}));
            end
            if (out_valid) begin
                check("out_valid_expected", 32'(sbq.size() != 0), 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq[0];
                    check("out_sum", 32'(out_sum), 32'(e.sum));
                    check("out_c",   32'(out_c),   32'(e.c));
                    check("out_ovf", 32'(out_ovf), 32'(e.ovf));
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        if (e.lat) check("latency", 32'(cyc - e.t), 32'(STG));
                        last_sum = out_sum; last_c = out_c; last_ovf = out_ovf;
                    end
                end
                if (!out_ready) check("in_ready_stall", 32'(in_ready), 32'd0);
            end else begin
                check("idle_hold", 32'({out_c, out_ovf, out_sum}), 32'({last_c, last_ovf, last_sum}));
                check("in_ready_idle", 32'(in_ready), 32'd1);
            end
            prev_stall = out_valid && !out_ready;
            prev_sum = out_sum; prev_c = out_c; prev_ovf = out_ovf;
            if (in_valid && in_ready) begin
                e = model(in_a, in_b, in_c, in_sub, cur_sat());
                e.t   = cyc;
                e.lat = cur_lat;
                sbq.push_back(e);
            end
        end
    end

    // Present one operation and hold it until accepted; returns at posedge+1
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic sub, input logic sat, input bit lat);
        int n;
        in_a = a; in_b = b; in_c = c; in_sub = sub; cur_lat = lat;
`ifdef CLA_ADDER_PIPE_SAT_EN
        in_sat = sat;
`else
        if (sat) $display("note: saturation requested in wrap-only build");
`endif
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cur_lat  = 1'b0;
    endtask

    // Directed vector: pin the model to a hand-computed result, then issue it
    task automatic pin(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic sub, input logic sat,
                       input logic [W-1:0] xs, input logic xc, input logic xo);
        exp_t e;
        e = model(a, b, c, sub, sat);
        check({name, "_model"}, 32'({e.c, e.ovf, e.sum}), 32'({xc, xo, xs}));
        send(a, b, c, sub, sat, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            in_valid  = 1'($urandom);
            in_a      = W'($urandom);
            in_b      = W'($urandom);
            in_c      = 1'($urandom);
            in_sub    = 1'($urandom);
            out_ready = 1'($urandom);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
        idle(1);

        pin("basic_add", 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        idle(6);
        pin("ripple",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        pin("pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        pin("sub_borrow",16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
        pin("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);
        pin("carry_in",  16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b0);
        idle(6);

        // Back-pressure: eight back-to-back ops with a 3-cycle output stall mid-stream
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(W'(i * 16'h1357), W'(16'hF0F0 - i * 16'h0321), 1'(i), 1'(i >> 1), 1'b0, 1'b0);
                end
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(8);

        // Op, bubble, op, then reset before anything reaches the output
        send(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        send(16'h3333, 16'h4444, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        pin("post_reset", 16'h00FF, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b0);
        idle(6);

`ifdef CLA_ADDER_PIPE_SAT_EN
        pin("sat_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        pin("sat_neg",  16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
        pin("wrap_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        pin("wrap_neg", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
`else
        pin("wrap_neg", 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
`endif

        n = 0;
        while (sbq.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
        end
        idle(2);
        check("drain_empty", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
